// File: rtl/ssp_pkg.sv
// Shared SSP constants used by the receive and transmit FIFOs.
package ssp_pkg;
  localparam int SSP_DATA_W     = 8;
  localparam int SSP_FIFO_DEPTH = 4;
  localparam int SSP_FIFO_PTR_W = 2;
  localparam int SSP_OVR_CNT_W  = 8;
endpackage

// File: rtl/ssp_rx_fifo_if.sv
// Receive FIFO bus: push strobe, APB-style read, status flags.
// SSP_RX_OVERRUN_CNT_EN adds the dropped-push counter signal.
interface ssp_rx_fifo_if
  import ssp_pkg::*;
#(
  parameter int WIDTH = SSP_DATA_W
);
  logic             write_fifo;
  logic [WIDTH-1:0] RxData;
  logic             PSEL;
  logic             PWRITE;
  logic [WIDTH-1:0] PRDATA;
  logic             rx_fifo_full;
  logic             rx_fifo_empty;
  logic             SSPRXINTR;
  logic             rx_overrun;
`ifdef SSP_RX_OVERRUN_CNT_EN
  logic [SSP_OVR_CNT_W-1:0] rx_overrun_cnt;
`endif

  modport master (
    output write_fifo, RxData, PSEL, PWRITE,
`ifdef SSP_RX_OVERRUN_CNT_EN
    input  rx_overrun_cnt,
`endif
    input  PRDATA, rx_fifo_full, rx_fifo_empty,
    input  SSPRXINTR, rx_overrun
  );

  modport slave (
    input  write_fifo, RxData, PSEL, PWRITE,
`ifdef SSP_RX_OVERRUN_CNT_EN
    output rx_overrun_cnt,
`endif
    output PRDATA, rx_fifo_full, rx_fifo_empty,
    output SSPRXINTR, rx_overrun
  );
endinterface

// File: rtl/ssp_fifo_ram.sv
// DEPTH x WIDTH register array, one write port, async read port.
module ssp_fifo_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/ssp_rx_fifo.sv
// SSP receive FIFO with registered read data and sticky overrun.
// SSP_RX_OVERRUN_CNT_EN adds a host-clearable dropped-push counter.
module ssp_rx_fifo
  import ssp_pkg::*;
#(
  parameter int DEPTH = SSP_FIFO_DEPTH,
  parameter int WIDTH = SSP_DATA_W,
  parameter int PTR_W = SSP_FIFO_PTR_W
) (
  input logic         PCLK,
  input logic         CLEAR_B,
  ssp_rx_fifo_if.slave bus
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [WIDTH-1:0] rd_word;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             drop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Full/empty are pre-edge: no look-ahead, no bypass.
  assign push = bus.write_fifo & ~full;
  assign drop = bus.write_fifo & full;
  assign pop  = bus.PSEL & ~bus.PWRITE & ~empty;

  ssp_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk   (PCLK),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (bus.RxData),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      bus.PRDATA <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        bus.PRDATA <= rd_word;
      end
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SSP_RX_OVERRUN_CNT_EN
  logic ack;
  assign ack = bus.PSEL & bus.PWRITE;

  // A drop coinciding with the host ack wins over the clear.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      bus.rx_overrun     <= 1'b0;
      bus.rx_overrun_cnt <= '0;
    end else if (ack) begin
      bus.rx_overrun     <= drop;
      bus.rx_overrun_cnt <= drop ? SSP_OVR_CNT_W'(1) : '0;
    end else if (drop) begin
      bus.rx_overrun <= 1'b1;
      if (bus.rx_overrun_cnt != '1)
        bus.rx_overrun_cnt <= bus.rx_overrun_cnt + SSP_OVR_CNT_W'(1);
    end
  end
`else
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) bus.rx_overrun <= 1'b0;
    else if (drop) bus.rx_overrun <= 1'b1;
  end
`endif

  assign bus.rx_fifo_full  = full;
  assign bus.rx_fifo_empty = empty;
  assign bus.SSPRXINTR     = full;
endmodule
